// File: rtl/multi_distance_sensor.sv
// Purpose : APB3 slave sequencing up to NUM_CH ultrasonic rangers round-robin, timing each echo pulse.
// Latency : START write -> trigger 1 cycle; echo pin -> FSM 2 cycles; DONE/TOUT/DIST same edge, irq +1.
// Backpressure: none; PREADY tied high, every APB access completes in its access phase.
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR   APB3 slave
//   echo[NUM_CH]                 asynchronous echo inputs (synchronised internally)
//   trigger[NUM_CH]              registered trigger pulses, one channel at a time
//   irq                          registered level interrupt
module multi_distance_sensor #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int TRIG_CYCLES = 1000,
  parameter int TIMEOUT     = 3800000
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  output logic              irq
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    cur_q, cur_d;
  logic [31:0]        cnt_q;
  logic [CNT_W-1:0]   width_q;
  logic [NUM_CH-1:0]  echo_meta, echo_s;
  logic               start_q, cont_q, irq_en_q, irq_q;
  logic [NUM_CH-1:0]  mask_q, done_q, tout_q, trig_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   dist_q [NUM_CH];

  // APB decode: only word index PADDR[7:2] matters
  logic [5:0]  widx, didx;
  logic        sel_ctrl, sel_stat, sel_gap, sel_dist, mapped, wr_en;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign widx     = PADDR[7:2];
  assign didx     = widx - 6'd4;
  assign sel_ctrl = (widx == 6'd0);
  assign sel_stat = (widx == 6'd1);
  assign sel_gap  = (widx == 6'd2);
  assign sel_dist = (widx >= 6'd4) && (widx < 6'(4 + NUM_CH));
  assign mapped   = sel_ctrl | sel_stat | sel_gap | sel_dist;
  assign wr_en    = PSEL & PENABLE & PWRITE & mapped;
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA, didx};

  // Channel search: lowest enabled, and lowest enabled strictly above cur_q
  logic            low_found, nxt_found;
  logic [CH_W-1:0] low_idx, nxt_idx;
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_found = 1'b1;
        low_idx   = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(cur_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = CH_W'(i);
      end
    end
  end

  logic echo_cur, trig_done, tout_hit, gap_done;
  assign echo_cur  = echo_s[cur_q];
  assign trig_done = (cnt_q == 32'(TRIG_CYCLES - 1));
  // The timeout counter spans WAIT_RISE and MEASURE without restarting
  assign tout_hit  = (cnt_q == 32'(TIMEOUT - 1));
  // A GAP of 0 still idles one cycle
  assign gap_done  = (gap_q == '0) || (cnt_q >= (32'(gap_q) - 32'd1));

  // FSM: state register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: if (start_q && low_found) begin
        state_d = TRIG;
        cur_d   = low_idx;
      end
      TRIG: if (trig_done) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (tout_hit)      state_d = GAP;
        else if (echo_cur) state_d = MEASURE;
      end
      MEASURE: if (tout_hit || !echo_cur) state_d = GAP;
      GAP: if (gap_done) begin
        if (nxt_found) begin
          state_d = TRIG;
          cur_d   = nxt_idx;
        end else if (cont_q && low_found) begin
          state_d = TRIG;
          cur_d   = low_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  logic              busy, load_dist;
  logic [NUM_CH-1:0] set_done, set_tout;
  logic [CNT_W-1:0]  dist_val;
  always_comb begin
    busy      = (state_q != IDLE);
    set_done  = '0;
    set_tout  = '0;
    load_dist = 1'b0;
    dist_val  = width_q;
    if (((state_q == WAIT_RISE) || (state_q == MEASURE)) && tout_hit) begin
      set_tout[cur_q] = 1'b1;
      load_dist       = 1'b1;
      dist_val        = '1;
    end else if ((state_q == MEASURE) && !echo_cur) begin
      set_done[cur_q] = 1'b1;
      load_dist       = 1'b1;
    end
  end

  // Datapath and register file
  logic [NUM_CH-1:0] clr_done, clr_tout;
  logic              wr_stat;
  assign wr_stat  = wr_en & sel_stat;
  assign clr_done = wr_stat ? PWDATA[8 +: NUM_CH]  : '0;
  assign clr_tout = wr_stat ? PWDATA[16 +: NUM_CH] : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      echo_meta <= '0;
      echo_s    <= '0;
      start_q   <= 1'b0;
      trig_q    <= '0;
      cnt_q     <= '0;
      width_q   <= '0;
      cont_q    <= 1'b0;
      mask_q    <= '0;
      gap_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= '0;
      tout_q    <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) dist_q[i] <= '0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      // START is a one-cycle request, dropped if a sweep is already running
      start_q   <= wr_en & sel_ctrl & PWDATA[0] & ~busy;
      trig_q    <= (state_d == TRIG) ? (NUM_CH'(1) << cur_d) : '0;

      if (state_d == IDLE)
        cnt_q <= '0;
      else if ((state_d != state_q) && !((state_q == WAIT_RISE) && (state_d == MEASURE)))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 32'd1;

      if (state_q == WAIT_RISE)    width_q <= CNT_W'(1);
      else if (state_q == MEASURE) width_q <= width_q + CNT_W'(1);

      if (wr_en && sel_ctrl) begin
        cont_q <= PWDATA[1];
        mask_q <= PWDATA[16 +: NUM_CH];
      end
      if (wr_en && sel_gap) gap_q    <= PWDATA[CNT_W-1:0];
      if (wr_stat)          irq_en_q <= PWDATA[24];

      // Hardware set overrides a simultaneous W1C
      done_q <= (done_q & ~clr_done) | set_done;
      tout_q <= (tout_q & ~clr_tout) | set_tout;
      if (load_dist) dist_q[cur_q] <= dist_val;

      irq_q <= irq_en_q & (|(done_q | tout_q));
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel_ctrl) begin
      rd_val[1]             = cont_q;
      rd_val[16 +: NUM_CH]  = mask_q;
    end else if (sel_stat) begin
      rd_val[0]             = busy;
      rd_val[8 +: NUM_CH]   = done_q;
      rd_val[16 +: NUM_CH]  = tout_q;
      rd_val[24]            = irq_en_q;
    end else if (sel_gap) begin
      rd_val[CNT_W-1:0]     = gap_q;
    end else if (sel_dist) begin
      rd_val[CNT_W-1:0]     = dist_q[didx[CH_W-1:0]];
    end
  end

  assign PRDATA  = (PSEL && !PWRITE) ? rd_val : 32'd0;
  assign PSLVERR = PSEL & PENABLE & ~mapped;
  assign PREADY  = 1'b1;
  assign trigger = trig_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_multi_distance_sensor.sv
// Purpose : directed + randomized check of multi_distance_sensor against a sensor/scoreboard model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_multi_distance_sensor;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int TRIG_CYCLES = 10;
  localparam int TIMEOUT     = 500;
  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_STAT  = 32'h04;
  localparam logic [31:0] A_GAP   = 32'h08;
  localparam logic [31:0] A_DIST0 = 32'h10;
  localparam logic [31:0] ALL_ONES = 32'((1 << CNT_W) - 1);
  localparam logic [NUM_CH-1:0] ONE_CH = 1;

  logic              PCLK = 1'b0;
  logic              PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA, PRDATA;
  logic              PREADY, PSLVERR, irq;
  logic [NUM_CH-1:0] echo, trigger;

  multi_distance_sensor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .echo(echo), .trigger(trigger), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Sensor behaviour per channel: echo rises s_delay cycles after trigger fall,
  // stays high s_width cycles (0 = never rises); s_hold keeps it high past the timeout.
  int  s_delay [NUM_CH];
  int  s_width [NUM_CH];
  bit  s_hold  [NUM_CH];
  bit  sensor_busy;
  int  onehot_err;
  int  tr_ch[$], tr_len[$], tr_rise[$], tr_fall[$];
  logic [31:0] exp_dist [NUM_CH];
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_dist(input int d, input int w, input bit hold);
    if (hold || (w == 0)) return ALL_ONES;
    if (d + w + 3 < TIMEOUT) return 32'(w);
    return ALL_ONES;
  endfunction

  task automatic clear_logs();
    tr_ch.delete(); tr_len.delete(); tr_rise.delete(); tr_fall.delete();
    onehot_err = 0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 last_err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 d = PRDATA;
    last_err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    apb_read(a, rd);
    check(tag, rd, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      apb_read(A_STAT, s);
      n++;
    end while (s[0] && (n < 3000));
    check({tag, " idle"}, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic run_sweep(input logic [NUM_CH-1:0] mask, input int gap, input string tag);
    logic [31:0] rd;
    int wr_cyc, gap_eff;
    int exp_ch[$];
    apb_write(A_STAT, 32'h00FF_FF00);
    apb_write(A_GAP, 32'(gap));
    clear_logs();
    apb_write(A_CTRL, (32'(mask) << 16) | 32'h1);
    wr_cyc = cyc;
    wait_idle(tag);
    gap_eff = (gap < 1) ? 1 : gap;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        exp_ch.push_back(c);
        exp_dist[c] = model_dist(s_delay[c], s_width[c], s_hold[c]);
      end
    end
    check({tag, " ntrig"}, tr_ch.size(), exp_ch.size());
    check({tag, " latency"}, (tr_rise.size() > 0) ? (tr_rise[0] - wr_cyc) : -1, 1);
    for (int k = 0; (k < tr_ch.size()) && (k < exp_ch.size()); k++) begin
      check({tag, " chan"}, tr_ch[k], exp_ch[k]);
      check({tag, " trig len"}, tr_len[k], TRIG_CYCLES);
      if (k > 0) check({tag, " idle gap"}, 32'((tr_rise[k] - tr_fall[k-1]) > gap_eff), 1);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      apb_read(A_DIST0 + 32'(4 * c), rd);
      check({tag, " dist"}, rd, exp_dist[c]);
    end
    read_check({tag, " status"}, A_STAT, 32'(mask) << 8);
    check({tag, " onehot"}, onehot_err, 0);
  endtask

  // Sensor model and trigger monitor
  initial begin : sensor
    int ch, len;
    echo = '0;
    sensor_busy = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (trigger != '0) begin
        sensor_busy = 1'b1;
        ch = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (trigger[i]) ch = i;
        if ($countones(trigger) != 1) onehot_err++;
        tr_ch.push_back(ch);
        tr_rise.push_back(cyc);
        len = 1;
        while (1) begin
          @(posedge PCLK); #1;
          if (trigger == '0) break;
          if (trigger != (ONE_CH << ch)) onehot_err++;
          len++;
        end
        tr_len.push_back(len);
        tr_fall.push_back(cyc);
        if (s_hold[ch] || (s_width[ch] > 0)) begin
          wait_cycles(s_delay[ch]);
          echo[ch] = 1'b1;
          wait_cycles(s_hold[ch] ? (TIMEOUT + 50) : s_width[ch]);
          echo[ch] = 1'b0;
        end
        sensor_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] rd;
    int n, f, t;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; last_err = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_delay[c] = 0; s_width[c] = 0; s_hold[c] = 1'b0; exp_dist[c] = '0;
    end
    repeat (3) @(posedge PCLK);
    #1;
    check("rst trigger", 32'(trigger), 0);
    check("rst irq", 32'(irq), 0);
    check("rst pready", 32'(PREADY), 1);
    check("rst pslverr", 32'(PSLVERR), 0);
    check("rst prdata", PRDATA, 0);
    PRESET = 1'b0;
    read_check("rst ctrl", A_CTRL, 0);
    read_check("rst status", A_STAT, 0);
    read_check("rst gap", A_GAP, 0);
    for (int c = 0; c < NUM_CH; c++) read_check("rst dist", A_DIST0 + 32'(4 * c), 0);

    // Single channel, fixed pulse
    s_delay[0] = 20; s_width[0] = 137;
    run_sweep(4'h1, 0, "single");

    // Sparse mask, then random masks/gaps/pulses
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s_delay[c] = $urandom_range(0, 40);
        s_width[c] = $urandom_range(1, 150);
      end
      if (it == 0) run_sweep(4'h5, 7, "mask5");
      else run_sweep(4'($urandom_range(1, 15)), $urandom_range(0, 10), "random");
    end

    // Timeouts: echo never rises, then echo stuck high
    for (int mode = 0; mode < 2; mode++) begin
      s_width[1] = 0; s_delay[1] = 3; s_hold[1] = (mode == 1);
      apb_write(A_STAT, 32'h00FF_FF00);
      clear_logs();
      apb_write(A_CTRL, (32'h2 << 16) | 32'h1);
      wait_idle("timeout");
      read_check("timeout dist", A_DIST0 + 32'd4, ALL_ONES);
      read_check("timeout status", A_STAT, 32'h1 << 17);
      n = 0;
      while (sensor_busy && (n < 1000)) begin wait_cycles(1); n++; end
    end
    s_hold[1] = 1'b0;

    // Continuous mode: three sweeps, then clear CONT
    s_delay[0] = 2; s_width[0] = 15; s_delay[1] = 4; s_width[1] = 9;
    apb_write(A_GAP, 32'd3);
    apb_write(A_STAT, 32'h00FF_FF00);
    clear_logs();
    apb_write(A_CTRL, (32'h3 << 16) | 32'h3);
    n = 0;
    while ((tr_ch.size() < 6) && (n < 5000)) begin wait_cycles(1); n++; end
    apb_write(A_CTRL, 32'h3 << 16);
    wait_idle("cont");
    wait_cycles(200);
    check("cont ntrig", tr_ch.size(), 6);
    for (int k = 0; k < tr_ch.size(); k++) check("cont order", tr_ch[k], k % 2);
    read_check("cont status", A_STAT, 32'h3 << 8);

    // Interrupt, and set-beats-clear on DONE[1]
    apb_write(A_STAT, 32'h01FF_FF00);
    wait_cycles(1);
    check("irq cleared", 32'(irq), 0);
    s_delay[1] = 5; s_width[1] = 30;
    clear_logs();
    apb_write(A_CTRL, (32'h2 << 16) | 32'h1);
    wait_idle("irq run1");
    check("irq set", 32'(irq), 1);
    read_check("irq status", A_STAT, (32'h1 << 24) | (32'h1 << 9));
    clear_logs();
    apb_write(A_CTRL, (32'h2 << 16) | 32'h1);
    n = 0;
    while ((tr_fall.size() < 1) && (n < 200)) begin wait_cycles(1); n++; end
    f = (tr_fall.size() > 0) ? tr_fall[0] : cyc;
    t = f + s_delay[1] + s_width[1] + 3;   // edge where DONE[1] sets again
    n = 0;
    while ((cyc < t - 2) && (n < 1000)) begin wait_cycles(1); n++; end
    apb_write(A_STAT, (32'h1 << 24) | (32'h1 << 9));
    wait_idle("irq run2");
    read_check("set wins", A_STAT, (32'h1 << 24) | (32'h1 << 9));
    check("irq held", 32'(irq), 1);
    apb_write(A_STAT, (32'h1 << 24) | (32'h1 << 9));
    check("irq lag", 32'(irq), 1);
    wait_cycles(1);
    check("irq drop", 32'(irq), 0);
    read_check("w1c status", A_STAT, 32'h1 << 24);

    // Unmapped accesses
    apb_read(32'h40, rd);
    check("unmapped rdata", rd, 0);
    check("unmapped slverr", 32'(last_err), 1);
    apb_read(32'h0C, rd);
    check("hole slverr", 32'(last_err), 1);
    apb_write(32'h0C, 32'hFFFF);
    check("hole wr slverr", 32'(last_err), 1);
    read_check("gap kept", A_GAP, 32'd3);
    check("mapped slverr", 32'(last_err), 0);

    // Reset while triggering
    s_delay[0] = 2; s_width[0] = 50;
    clear_logs();
    apb_write(A_CTRL, (32'h1 << 16) | 32'h1);
    n = 0;
    while ((trigger == '0) && (n < 50)) begin wait_cycles(1); n++; end
    check("pre-reset trig", 32'(trigger), 1);
    PRESET = 1'b1;
    wait_cycles(1);
    check("reset drops trig", 32'(trigger), 0);
    PRESET = 1'b0;
    n = 0;
    while (sensor_busy && (n < 500)) begin wait_cycles(1); n++; end

    // Reset while measuring
    apb_write(A_STAT, 32'h1 << 24);
    apb_write(A_GAP, 32'd5);
    s_delay[0] = 2; s_width[0] = 200;
    clear_logs();
    apb_write(A_CTRL, (32'h1 << 16) | 32'h1);
    n = 0;
    while ((tr_fall.size() < 1) && (n < 200)) begin wait_cycles(1); n++; end
    wait_cycles(20);
    read_check("measuring busy", A_STAT, (32'h1 << 24) | 32'h1);
    PRESET = 1'b1;
    wait_cycles(1);
    PRESET = 1'b0;
    read_check("post-reset status", A_STAT, 0);
    read_check("post-reset ctrl", A_CTRL, 0);
    read_check("post-reset gap", A_GAP, 0);
    read_check("post-reset dist0", A_DIST0, 0);
    check("post-reset trig", 32'(trigger), 0);
    check("post-reset irq", 32'(irq), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
